fetch_queue: RTL and testbench

Instruction buffer between the fetch stage and decode. Captures each fetched 32-bit instruction word with its 64-bit PC in a small FIFO, tags it as a 16-bit or 32-bit instruction, and presents entries to decode through a valid/ready handshake. Fetch can keep running while decode stalls. A flush from branch resolution discards all buffered instructions.

---
 rtl/fetch_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction buffer between fetch and decode. Each fetched 32-bit word is
// stored with its 64-bit PC and a long/short tag in a DEPTH-entry circular
// FIFO. The head entry is presented to decode through a valid/ready handshake.
// A flush from branch resolution, or reset, empties the queue.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high; empties the queue
//   flush            discard all buffered entries (beats push and pop)
//   in_valid         fetch presents a word this cycle
//   in_ready         queue has room (depends only on registered count)
//   in_pc            PC of the presented word
//   in_instruction   presented instruction word
//   out_valid        head entry is valid
//   out_ready        decode consumes the head this cycle
//   out_pc           PC of the head entry
//   out_instruction  instruction word of the head entry
//   out_is_long      head is a 32-bit instruction (bits [31:30] == 2'b11)
//   out_next_pc      head PC + 4 for long, + 2 for short (wraps mod 2^64)
//   count            number of valid entries, 0..DEPTH
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_pc,
  input  logic [31:0]       in_instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_pc,
  output logic [31:0]       out_instruction,
  output logic              out_is_long,
  output logic [63:0]       out_next_pc,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   COUNT_ZERO = (PTR_W + 1)'(0);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);

  // A 32-bit instruction is marked by both low-order opcode bits set,
  // which sit at [31:30] in this word layout.
  function automatic logic is_long_f(input logic [31:0] instruction);
    return (instruction[31:30] == 2'b11);
  endfunction

  // Sequential PC of the following instruction; the add wraps naturally.
  function automatic logic [63:0] next_pc_f(input logic [63:0] pc, input logic is_long);
    logic [63:0] step;
    if (is_long) begin
      step = 64'd4;
    end else begin
      step = 64'd2;
    end
    return pc + step;
  endfunction

  logic [63:0]      pc_mem_r    [0:DEPTH-1];
  logic [31:0]      instr_mem_r [0:DEPTH-1];
  logic             long_mem_r  [0:DEPTH-1];

  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W:0]   count_r;

  logic [PTR_W-1:0] rd_ptr_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W:0]   count_s;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;

  // Handshake qualifiers come from registered count only, so a full queue
  // refuses a push even in a cycle where decode pops.
  assign in_ready_s  = (count_r != FULL_COUNT);
  assign out_valid_s = (count_r != COUNT_ZERO);
  assign push_s      = in_valid && in_ready_s;
  assign pop_s       = out_valid_s && out_ready;

  // Next-state for pointers and occupancy; reset and flush both empty the queue.
  always_comb begin
    rd_ptr_s = rd_ptr_r;
    wr_ptr_s = wr_ptr_r;
    count_s  = count_r;
    if (reset || flush) begin
      rd_ptr_s = PTR_ZERO;
      wr_ptr_s = PTR_ZERO;
      count_s  = COUNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + COUNT_ONE;
        2'b01:   count_s = count_r - COUNT_ONE;
        default: count_s = count_r;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    rd_ptr_r <= rd_ptr_s;
    wr_ptr_r <= wr_ptr_s;
    count_r  <= count_s;
  end

  // Entry storage; a word arriving in a flush/reset cycle is dropped.
  always_ff @(posedge clock) begin
    if (push_s && !flush && !reset) begin
      pc_mem_r[wr_ptr_r]    <= in_pc;
      instr_mem_r[wr_ptr_r] <= in_instruction;
      long_mem_r[wr_ptr_r]  <= is_long_f(in_instruction);
    end
  end

  // Head fields read straight from storage; stale when out_valid is low.
  assign out_pc          = pc_mem_r[rd_ptr_r];
  assign out_instruction = instr_mem_r[rd_ptr_r];
  assign out_is_long     = long_mem_r[rd_ptr_r];
  assign out_next_pc     = next_pc_f(pc_mem_r[rd_ptr_r], long_mem_r[rd_ptr_r]);

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign count     = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_pc;
  logic [31:0]       in_instruction;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_pc;
  logic [31:0]       out_instruction;
  logic              out_is_long;
  logic [63:0]       out_next_pc;
  logic [PTR_W:0]    count;

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instruction(in_instruction),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instruction(out_instruction), .out_is_long(out_is_long),
    .out_next_pc(out_next_pc), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t model_q[$];
  entry_t model_popped_q[$];
  entry_t dut_popped_q[$];
  int     compared   = 0;
  int     mismatched = 0;
  bit     last_push  = 1'b0;

  // Expected {out_valid, in_ready, count} from the model's occupancy.
  function automatic logic [4:0] exp_status();
    int n;
    n = model_q.size();
    return {(n != 0), (n != DEPTH), 3'(n)};
  endfunction

  // Expected {pc, instruction, is_long, next_pc} of the model's head.
  function automatic logic [160:0] exp_head();
    entry_t e;
    logic   lg;
    e  = model_q[0];
    lg = (e.instr[31:30] == 2'b11);
    return {e.pc, e.instr, lg, e.pc + (lg ? 64'd4 : 64'd2)};
  endfunction

  // One clock: log observed transfer, advance model with the edge's inputs.
  task automatic cycle();
    bit push;
    bit pop;
    if (out_valid && out_ready && !flush && !reset)
      dut_popped_q.push_back({out_pc, out_instruction});
    push = in_valid && (model_q.size() != DEPTH);
    pop  = out_ready && (model_q.size() != 0);
    @(posedge clock);
    if (reset || flush) begin
      model_q.delete();
      last_push = 1'b0;
    end else begin
      if (pop) begin
        model_popped_q.push_back(model_q[0]);
        void'(model_q.pop_front());
      end
      if (push) model_q.push_back({in_pc, in_instruction});
      last_push = push;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    compared++;
    if ({out_valid, in_ready, count} !== 5'b01000) begin
      mismatched++;
      $display("FAIL reset_state: got %b want %b", {out_valid, in_ready, count}, 5'b01000);
    end
    compared++;
    if ({out_valid, in_ready, count} !== exp_status()) begin
      mismatched++;
      $display("FAIL reset_model: got %b want %b", {out_valid, in_ready, count}, exp_status());
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 64'h0; in_instruction = 32'h0000_0001;
    cycle();
    in_pc = 64'h2; in_instruction = 32'hFFFF_FFFF;
    compared++;
    if ({out_valid, out_instruction, out_is_long, out_next_pc} !== {1'b1, 32'h1, 1'b0, 64'h2}) begin
      mismatched++;
      $display("FAIL basic_head1: got %h want %h", {out_valid, out_instruction, out_is_long, out_next_pc},
               {1'b1, 32'h1, 1'b0, 64'h2});
    end
    cycle();
    in_valid = 1'b0;
    compared++;
    if ({out_valid, count, out_instruction, out_is_long, out_next_pc} !== {1'b1, 3'd1, 32'hFFFF_FFFF, 1'b1, 64'h6}) begin
      mismatched++;
      $display("FAIL basic_head2: got %h want %h", {out_valid, count, out_instruction, out_is_long, out_next_pc},
               {1'b1, 3'd1, 32'hFFFF_FFFF, 1'b1, 64'h6});
    end
    cycle();
    compared++;
    if ({out_valid, count} !== 4'b0000) begin
      mismatched++;
      $display("FAIL basic_empty: got %b want %b", {out_valid, count}, 4'b0000);
    end
  endtask

  task automatic test_full();
    int guard;
    dut_popped_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 64'(2 * i); in_instruction = 32'h10 + 32'(i);
      cycle();
    end
    compared++;
    if ({in_ready, count} !== {1'b0, 3'd4}) begin
      mismatched++;
      $display("FAIL full_state: got %b want %b", {in_ready, count}, {1'b0, 3'd4});
    end
    in_pc = 64'h8; in_instruction = 32'h14;
    cycle();
    compared++;
    if ({count, out_instruction} !== {3'd4, 32'h10}) begin
      mismatched++;
      $display("FAIL full_reject: got %h want %h", {count, out_instruction}, {3'd4, 32'h10});
    end
    out_ready = 1'b1;
    guard = 0;
    while (!last_push && guard < 10) begin
      cycle();
      guard++;
    end
    in_valid = 1'b0;
    while (out_valid && guard < 20) begin
      cycle();
      guard++;
    end
    compared++;
    if (guard >= 20 || dut_popped_q.size() != 5) begin
      mismatched++;
      $display("FAIL full_drain_len: got %0d entries want 5 (guard %0d)", dut_popped_q.size(), guard);
    end else begin
      for (int i = 0; i < 5; i++) begin
        compared++;
        if (dut_popped_q[i].instr !== 32'h10 + 32'(i)) begin
          mismatched++;
          $display("FAIL full_order[%0d]: got %h want %h", i, dut_popped_q[i].instr, 32'h10 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    dut_popped_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = 64'(4 * i); in_instruction = 32'(i);
      cycle();
      compared++;
      if (count !== 3'd1) begin
        mismatched++;
        $display("FAIL wrap_count[%0d]: got %0d want 1", i, count);
      end
    end
    in_valid = 1'b0;
    cycle();
    compared++;
    if (dut_popped_q.size() != 10) begin
      mismatched++;
      $display("FAIL wrap_len: got %0d want 10", dut_popped_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        compared++;
        if (dut_popped_q[i].instr !== 32'(i)) begin
          mismatched++;
          $display("FAIL wrap_order[%0d]: got %h want %h", i, dut_popped_q[i].instr, 32'(i));
        end
      end
    end
  endtask

  task automatic test_flush();
    dut_popped_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 64'(2 * i); in_instruction = 32'h20 + 32'(i);
      cycle();
    end
    compared++;
    if (count !== 3'd3) begin
      mismatched++;
      $display("FAIL flush_prefill: got %0d want 3", count);
    end
    flush = 1'b1; in_instruction = 32'hAA;
    cycle();
    flush = 1'b0;
    compared++;
    if ({out_valid, in_ready, count} !== 5'b01000) begin
      mismatched++;
      $display("FAIL flush_empty: got %b want %b", {out_valid, in_ready, count}, 5'b01000);
    end
    in_pc = 64'h100; in_instruction = 32'hBB;
    cycle();
    in_valid = 1'b0;
    compared++;
    if ({out_valid, count, out_instruction} !== {1'b1, 3'd1, 32'hBB}) begin
      mismatched++;
      $display("FAIL flush_next_head: got %h want %h", {out_valid, count, out_instruction}, {1'b1, 3'd1, 32'hBB});
    end
    out_ready = 1'b1;
    cycle();
    compared++;
    if (dut_popped_q.size() != 1 || dut_popped_q[0].instr !== 32'hBB || count !== 3'd0) begin
      mismatched++;
      $display("FAIL flush_drain: got %0d entries count %0d want only BB, count 0", dut_popped_q.size(), count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 64'(2 * i); in_instruction = 32'h30 + 32'(i);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1; reset = 1'b1;
    cycle();
    reset = 1'b0; out_ready = 1'b0;
    compared++;
    if ({out_valid, in_ready, count} !== 5'b01000) begin
      mismatched++;
      $display("FAIL reset_mid_state: got %b want %b", {out_valid, in_ready, count}, 5'b01000);
    end
    in_valid = 1'b1; in_pc = 64'h40; in_instruction = 32'h40;
    cycle();
    in_valid = 1'b0;
    compared++;
    if ({count, out_instruction} !== {3'd1, 32'h40}) begin
      mismatched++;
      $display("FAIL reset_mid_head: got %h want %h", {count, out_instruction}, {3'd1, 32'h40});
    end
    out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_pc_wrap();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'hFFFF_FFFF_FFFF_FFFE; in_instruction = 32'hC000_0000;
    cycle();
    in_valid = 1'b0;
    compared++;
    if ({out_pc, out_is_long, out_next_pc} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'h2}) begin
      mismatched++;
      $display("FAIL pc_wrap: got %h want %h", {out_pc, out_is_long, out_next_pc},
               {64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'h2});
    end
    out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    dut_popped_q.delete();
    model_popped_q.delete();
    for (int i = 0; i < 400; i++) begin
      // Hold a rejected word stable; otherwise pick a fresh one.
      if (!(in_valid && model_q.size() == DEPTH)) begin
        in_valid       = ($urandom_range(0, 3) != 0);
        in_pc          = {$urandom, $urandom};
        in_instruction = $urandom;
      end
      out_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      cycle();
      compared++;
      if ({out_valid, in_ready, count} !== exp_status()) begin
        mismatched++;
        $display("FAIL rand_status[%0d]: got %b want %b", i, {out_valid, in_ready, count}, exp_status());
      end
      if (model_q.size() != 0) begin
        compared++;
        if ({out_pc, out_instruction, out_is_long, out_next_pc} !== exp_head()) begin
          mismatched++;
          $display("FAIL rand_head[%0d]: got %h want %h", i,
                   {out_pc, out_instruction, out_is_long, out_next_pc}, exp_head());
        end
      end
    end
    flush = 1'b0; reset = 1'b0; in_valid = 1'b0;
    compared++;
    if (dut_popped_q.size() != model_popped_q.size()) begin
      mismatched++;
      $display("FAIL rand_pop_count: got %0d want %0d", dut_popped_q.size(), model_popped_q.size());
    end else begin
      for (int i = 0; i < model_popped_q.size(); i++) begin
        if (dut_popped_q[i] !== model_popped_q[i]) begin
          compared++;
          mismatched++;
          $display("FAIL rand_pop_order[%0d]: got %h want %h", i, dut_popped_q[i], model_popped_q[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 64'h0; in_instruction = 32'h0;
    #1;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_pc_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
